// File: rtl/addsub_pipe_if.sv
// addsub_pipe_if: valid/ready operand and result bundle for addsub_pipe.
interface addsub_pipe_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_ctrl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_o;
    logic             out_cout;
    logic             out_ovf;

    modport master(output in_valid, in_a, in_b, in_cin, in_ctrl, out_ready,
                   input in_ready, out_valid, out_o, out_cout, out_ovf);
    modport slave(input in_valid, in_a, in_b, in_cin, in_ctrl, out_ready,
                  output in_ready, out_valid, out_o, out_cout, out_ovf);
endinterface

// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined controlled add/subtract with a valid/ready handshake.
// Operand a is inverted up front; each stage resolves one CHUNK of the carry chain.
module addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic          clk,
    input logic          rst_n,
    addsub_pipe_if.slave bus
);
    localparam int STAGES = (WIDTH + CHUNK - 1) / CHUNK;

    logic [STAGES-1:0] rv;
    logic [STAGES-1:0] ld;
    logic [WIDTH-1:0]  ra [STAGES];
    logic [WIDTH-1:0]  rb [STAGES];
    logic [WIDTH-1:0]  rr [STAGES];
    logic              rc [STAGES];
    logic              rovf;
    logic [WIDTH-1:0]  sa [STAGES];
    logic [WIDTH-1:0]  sb [STAGES];
    logic [WIDTH-1:0]  sr [STAGES];
    logic [WIDTH-1:0]  nr [STAGES];
    logic              sc [STAGES];
    logic              sv [STAGES];
    logic              nc [STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g
        localparam int LO = k * CHUNK;
        localparam int N  = (k == STAGES - 1) ? WIDTH - LO : CHUNK;
        logic [N:0] s;
        if (k == 0) begin : g_src
            assign sa[k] = bus.in_a ^ {WIDTH{bus.in_ctrl}};
            assign sb[k] = bus.in_b;
            assign sr[k] = '0;
            assign sc[k] = bus.in_cin ^ bus.in_ctrl;
            assign sv[k] = bus.in_valid;
        end else begin : g_src
            assign sa[k] = ra[k-1];
            assign sb[k] = rb[k-1];
            assign sr[k] = rr[k-1];
            assign sc[k] = rc[k-1];
            assign sv[k] = rv[k-1];
        end
        assign s     = {1'b0, sa[k][LO +: N]} + {1'b0, sb[k][LO +: N]} + {{N{1'b0}}, sc[k]};
        assign nr[k] = sr[k] | (WIDTH'(s[N-1:0]) << LO);
        assign nc[k] = s[N];
        // a stage can load unless it and every stage after it is full and the sink stalls
        assign ld[k] = bus.out_ready | ~&rv[STAGES-1:k];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rv   <= '0;
            rovf <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                ra[k] <= '0;
                rb[k] <= '0;
                rr[k] <= '0;
                rc[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    rv[k] <= sv[k];
                    ra[k] <= sa[k];
                    rb[k] <= sb[k];
                    rr[k] <= nr[k];
                    rc[k] <= nc[k];
                end
            end
            // carry into the MSB equals a ^ b ^ sum at that bit
            if (ld[STAGES-1])
                rovf <= sa[STAGES-1][WIDTH-1] ^ sb[STAGES-1][WIDTH-1] ^ nr[STAGES-1][WIDTH-1] ^ nc[STAGES-1];
        end
    end

    assign bus.in_ready  = ld[0];
    assign bus.out_valid = rv[STAGES-1];
    assign bus.out_o     = rr[STAGES-1];
    assign bus.out_cout  = rc[STAGES-1];
    assign bus.out_ovf   = rovf;
endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: scoreboard bench for addsub_pipe (16/4 directed, 8/3 and 8/8 random sweep).
module tb_addsub_pipe;
    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        ctrl;
        logic [15:0] o;
        logic        c;
        logic        v;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_s = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [17:0] q[$];
    logic [17:0] held = '0;
    logic        hv = 1'b0;

    always #5 clk = ~clk;

    addsub_pipe_if #(.WIDTH(16)) bus ();
    addsub_pipe #(.WIDTH(16), .CHUNK(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    vec_t dir [6] = '{
        '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0},
        '{16'h0001, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0},
        '{16'h0001, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0},
        '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
        '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0},
        '{16'h0001, 16'h8000, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1}
    };
    vec_t bp [8] = '{
        '{16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0},
        '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0},
        '{16'h0FFF, 16'h0001, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0},
        '{16'h0005, 16'h0003, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0},
        '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0},
        '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1},
        '{16'h8000, 16'h0000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1},
        '{16'hABCD, 16'h1234, 1'b1, 1'b0, 16'hBE02, 1'b0, 1'b0}
    };

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", n, got, exp);
        end
    endtask

    // arithmetic reference: unsigned range for carry, signed range for overflow
    function automatic logic [9:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic ct);
        int r;
        int s;
        logic c;
        if (!ct) begin
            r = int'(a) + int'(b) + int'({7'd0, ci});
            s = int'($signed(a)) + int'($signed(b)) + int'({7'd0, ci});
            c = r > 255;
        end else begin
            r = int'(b) - int'(a) - int'({7'd0, ci});
            s = int'($signed(b)) - int'($signed(a)) - int'({7'd0, ci});
            c = r >= 0;
        end
        return {r[7:0], c, (s > 127) || (s < -128)};
    endfunction

    task automatic step(input logic vld, input vec_t t, input logic ordy, output logic acc, output logic ov);
        @(negedge clk);
        bus.in_valid  = vld;
        bus.in_a      = t.a;
        bus.in_b      = t.b;
        bus.in_cin    = t.cin;
        bus.in_ctrl   = t.ctrl;
        bus.out_ready = ordy;
        #1;
        ov = bus.out_valid;
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, ordy || q.size() < 4});
        acc = vld && bus.in_ready;
        if (acc) q.push_back({t.o, t.c, t.v});
    endtask

    task automatic drain();
        logic acc, ov;
        for (int i = 0; i < 50 && q.size() != 0; i++) step(1'b0, dir[0], 1'b1, acc, ov);
        chk("drain", q.size(), 0);
    endtask

    task automatic check_idle(input string n);
        chk({n, "_out_valid"}, {31'd0, bus.out_valid}, 0);
        chk({n, "_in_ready"}, {31'd0, bus.in_ready}, 1);
        chk({n, "_out_o"}, {16'd0, bus.out_o}, 0);
        chk({n, "_cout"}, {31'd0, bus.out_cout}, 0);
        chk({n, "_ovf"}, {31'd0, bus.out_ovf}, 0);
    endtask

    always @(negedge clk) begin
        #2;
        if (!rst_n) hv = 1'b0;
        else begin
            if (hv) begin
                chk("stall_valid", {31'd0, bus.out_valid}, 1);
                chk("stall_data", {14'd0, bus.out_o, bus.out_cout, bus.out_ovf}, {14'd0, held});
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("pending", {31'd0, q.size() != 0}, 1);
                if (q.size() != 0) chk("result", {14'd0, bus.out_o, bus.out_cout, bus.out_ovf}, {14'd0, q.pop_front()});
            end
            hv = bus.out_valid && !bus.out_ready;
            held = {bus.out_o, bus.out_cout, bus.out_ovf};
        end
    end

    for (genvar g = 0; g < 2; g++) begin : sw
        localparam int C  = (g == 0) ? 3 : 8;
        localparam int ST = (8 + C - 1) / C;
        logic [9:0] sq[$];
        logic done = 1'b0;
        addsub_pipe_if #(.WIDTH(8)) sif ();
        addsub_pipe #(.WIDTH(8), .CHUNK(C)) dut (.clk(clk), .rst_n(rst_s), .bus(sif));

        initial begin
            int n;
            logic [7:0] a, b;
            logic ci, ct;
            n = 0;
            sif.in_valid = 1'b0; sif.in_a = '0; sif.in_b = '0;
            sif.in_cin = 1'b0; sif.in_ctrl = 1'b0; sif.out_ready = 1'b0;
            repeat (6) @(negedge clk);
            for (int cyc = 0; cyc < 20000 && (n < 1000 || sq.size() != 0); cyc++) begin
                @(negedge clk);
                a = 8'($urandom);
                b = 8'($urandom);
                ci = 1'($urandom);
                ct = 1'($urandom);
                sif.in_valid = (n < 1000) && ($urandom_range(0, 1) == 1);
                sif.in_a = a; sif.in_b = b; sif.in_cin = ci; sif.in_ctrl = ct;
                sif.out_ready = $urandom_range(0, 3) != 0;
                #1;
                chk($sformatf("sw%0d_in_ready", C), {31'd0, sif.in_ready}, {31'd0, sif.out_ready || sq.size() < ST});
                if (sif.in_valid && sif.in_ready) begin
                    sq.push_back(ref8(a, b, ci, ct));
                    n++;
                end
            end
            chk($sformatf("sw%0d_issued", C), n, 1000);
            chk($sformatf("sw%0d_empty", C), sq.size(), 0);
            done = 1'b1;
        end

        always @(negedge clk) begin
            #2;
            if (rst_s && sif.out_valid && sif.out_ready) begin
                chk($sformatf("sw%0d_pending", C), {31'd0, sq.size() != 0}, 1);
                if (sq.size() != 0)
                    chk($sformatf("sw%0d_result", C), {22'd0, sif.out_o, sif.out_cout, sif.out_ovf}, {22'd0, sq.pop_front()});
            end
        end
    end

    initial begin
        repeat (4) @(negedge clk);
        rst_s = 1'b1;
    end

    initial begin
        logic acc, ov, saw_full;
        int idx;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
        bus.in_cin = 1'b0; bus.in_ctrl = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1 check_idle("reset");
        rst_n = 1'b1;

        step(1'b1, dir[0], 1'b1, acc, ov);
        chk("lat_accept", {31'd0, acc}, 1);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, dir[0], 1'b1, acc, ov);
            chk($sformatf("lat_valid%0d", i), {31'd0, ov}, {31'd0, i == 4});
        end
        for (int i = 1; i < 6; i++) begin
            step(1'b1, dir[i], 1'b1, acc, ov);
            chk($sformatf("dir_accept%0d", i), {31'd0, acc}, 1);
        end
        drain();

        idx = 0;
        saw_full = 1'b0;
        for (int cyc = 0; cyc < 40 && (idx < 8 || q.size() != 0); cyc++) begin
            step(idx < 8, bp[idx % 8], !(cyc >= 2 && cyc <= 7), acc, ov);
            if (!bus.in_ready && q.size() == 4) saw_full = 1'b1;
            if (acc) idx++;
        end
        chk("bp_issued", idx, 8);
        chk("bp_full_seen", {31'd0, saw_full}, 1);
        chk("bp_drained", q.size(), 0);

        for (int i = 0; i < 3; i++) step(1'b1, bp[i], 1'b1, acc, ov);
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        q.delete();
        @(negedge clk);
        #1 check_idle("midrst");
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0, dir[0], 1'b1, acc, ov);

        for (int i = 0; i < 40000 && !(sw[0].done && sw[1].done); i++) @(negedge clk);
        chk("sweeps_done", {31'd0, sw[0].done && sw[1].done}, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
